// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART receiver and the future transmitter:
//   the parity-mode encodings, the receive FSM state encodings and a small
//   3-input majority helper used for bit voting.
package uart_pkg;

  // Parity mode encodings, matched against the PARITY_MODE parameter.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // One-hot receive FSM states.
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } rx_state_t;

  // Two-out-of-three vote over the samples taken around the bit centre.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive word FIFO for the UART receiver. The head word is presented
//   combinationally; when the FIFO is empty the output holds the last word
//   that was popped (zero after reset).
//
// Ports
//   clk      : clock, all state on the rising edge
//   rst      : asynchronous active-low reset, empties the FIFO
//   push     : write wdata this cycle (dropped when full and not popping)
//   wdata    : word to write
//   pop      : remove the head word this cycle (ignored when empty)
//   rdata    : head word, or last popped word when empty
//   empty    : FIFO holds no words
//   dropped  : one-cycle pulse, a push was discarded because the FIFO was full
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot in the same cycle, so a push into a full FIFO that
  // is being popped still succeeds and is not counted as a drop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & full & ~do_pop;

  assign rdata = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parameterised oversampling UART receiver with a receive FIFO and sticky
//   error flags. Each bit is decided by a 3-sample majority vote around the
//   bit centre; good frames are pushed into the FIFO, errored frames are
//   dropped and flagged.
//
// Ports
//   clk_sample : sample clock at OVERSAMPLE x baud rate
//   rst        : asynchronous active-low reset
//   rxd        : serial input, asynchronous, idle high
//   rdn        : active-low read strobe, pops one word per low cycle
//   clr_err    : one-cycle pulse clearing the sticky error flags
//   dout       : FIFO head word (last popped word while empty)
//   data_ready : FIFO not empty
//   frame_err  : sticky, a stop bit was sampled low
//   parity_err : sticky, a parity mismatch was seen
//   overrun    : sticky, a good frame was lost because the FIFO was full
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk_sample,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rdn,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] dout,
  output logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int PHASE_W = $clog2(OVERSAMPLE);
  localparam int CNT_W   = $clog2(DATA_BITS + 1);

  localparam logic [PHASE_W-1:0] PH_A    = PHASE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PHASE_W-1:0] PH_B    = PHASE_W'(OVERSAMPLE / 2);
  localparam logic [PHASE_W-1:0] PH_C    = PHASE_W'(OVERSAMPLE / 2 + 1);
  localparam logic [PHASE_W-1:0] PH_END  = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DATA_BITS);
  localparam logic [1:0]         STOP_LAST = 2'(STOP_BITS - 1);

  logic sync1;
  logic sync2;
  logic rxd_prev;
  logic rxd_s;

  rx_state_t state_q;
  rx_state_t state_d;
  logic [PHASE_W-1:0]   phase_q;
  logic [PHASE_W-1:0]   phase_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [CNT_W-1:0]     bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 parity_bit_q;
  logic                 parity_bit_d;
  logic [1:0]           stop_cnt_q;
  logic [1:0]           stop_cnt_d;
  logic                 frame_bad_q;
  logic                 frame_bad_d;
  logic                 push_q;
  logic                 push_d;
  logic                 samp_a_q;
  logic                 samp_b_q;

  logic fall;
  logic decide;
  logic bit_end;
  logic vote;
  logic parity_mismatch;
  logic set_frame;
  logic set_parity;
  logic fifo_empty;
  logic dropped;
  logic pop_req;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  // All three reset to the idle line level so reset never looks like a start.
  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync1    <= rxd;
      sync2    <= sync1;
      rxd_prev <= sync2;
    end
  end

  assign rxd_s   = sync2;
  assign fall    = rxd_prev & ~rxd_s;
  assign decide  = (phase_q == PH_C);
  assign bit_end = (phase_q == PH_END);

  // The first two votes are stored; the third is the live sample at the
  // decision phase, so the bit value is available in that same cycle.
  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else begin
      if (phase_q == PH_A) begin
        samp_a_q <= rxd_s;
      end
      if (phase_q == PH_B) begin
        samp_b_q <= rxd_s;
      end
    end
  end

  assign vote = majority3(samp_a_q, samp_b_q, rxd_s);

  assign parity_mismatch = (^shift_q) ^ parity_bit_q ^ (PARITY_MODE == PARITY_ODD);

  // Next-state logic. The phase counter free-runs within a bit and wraps at
  // the bit end; leaving STOP happens at the decision point of the last stop
  // bit so a start bit arriving right after it is not missed.
  always_comb begin
    state_d      = state_q;
    phase_d      = bit_end ? '0 : phase_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_bit_d = parity_bit_q;
    stop_cnt_d   = stop_cnt_q;
    frame_bad_d  = frame_bad_q;
    push_d       = 1'b0;
    set_frame    = 1'b0;
    set_parity   = 1'b0;

    unique case (state_q)
      IDLE: begin
        phase_d     = '0;
        frame_bad_d = 1'b0;
        if (fall) begin
          state_d = START;
        end
      end

      START: begin
        bit_cnt_d = '0;
        if (decide && vote) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (decide && (bit_cnt_q != CNT_MAX)) begin
          shift_d   = {vote, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (bit_end && (bit_cnt_q == CNT_MAX)) begin
          state_d    = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
          stop_cnt_d = '0;
        end
      end

      PARITY: begin
        if (decide) begin
          parity_bit_d = vote;
        end
        if (bit_end) begin
          state_d    = STOP;
          stop_cnt_d = '0;
        end
      end

      STOP: begin
        if (decide) begin
          if (!vote) begin
            set_frame = 1'b1;
          end
          if (stop_cnt_q == STOP_LAST) begin
            state_d = IDLE;
            phase_d = '0;
            if ((PARITY_MODE != PARITY_NONE) && parity_mismatch) begin
              set_parity = 1'b1;
            end
            push_d = vote & ~frame_bad_q & ~set_parity;
          end else begin
            stop_cnt_d  = stop_cnt_q + 1'b1;
            frame_bad_d = frame_bad_q | ~vote;
          end
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_bit_q <= 1'b0;
      stop_cnt_q   <= '0;
      frame_bad_q  <= 1'b0;
      push_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_bit_q <= parity_bit_d;
      stop_cnt_q   <= stop_cnt_d;
      frame_bad_q  <= frame_bad_d;
      push_q       <= push_d;
    end
  end

  // Sticky flags: a set event in the same cycle as clr_err wins.
  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= set_frame  | (frame_err  & ~clr_err);
      parity_err <= set_parity | (parity_err & ~clr_err);
      overrun    <= dropped    | (overrun    & ~clr_err);
    end
  end

  assign pop_req = ~rdn;

  // shift_q is stable for a whole bit after the last stop decision, so it can
  // feed the FIFO directly in the push cycle.
  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_sample),
    .rst     (rst),
    .push    (push_q),
    .wdata   (shift_q),
    .pop     (pop_req),
    .rdata   (dout),
    .empty   (fifo_empty),
    .dropped (dropped)
  );

  assign data_ready = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
//   Directed bench for uart_rx_param. Three receivers share one clock and
//   reset: index 0 is 8N1, index 1 is 8E1, index 2 is 8N2, all with
//   OVERSAMPLE=16 and FIFO_DEPTH=4. Each has its own serial line and
//   read/clear strobes.
module tb_uart_rx_param;

  logic       clk;
  logic       rst;
  logic       rxd_v   [3];
  logic       rdn_v   [3];
  logic       clr_v   [3];
  logic [7:0] dout_v  [3];
  logic       ready_v [3];
  logic       ferr_v  [3];
  logic       perr_v  [3];
  logic       ovr_v   [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop_val;
    logic       exp_ready;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  uart_rx_param #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_8n1 (
    .clk_sample (clk),
    .rst        (rst),
    .rxd        (rxd_v[0]),
    .rdn        (rdn_v[0]),
    .clr_err    (clr_v[0]),
    .dout       (dout_v[0]),
    .data_ready (ready_v[0]),
    .frame_err  (ferr_v[0]),
    .parity_err (perr_v[0]),
    .overrun    (ovr_v[0])
  );

  uart_rx_param #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_8e1 (
    .clk_sample (clk),
    .rst        (rst),
    .rxd        (rxd_v[1]),
    .rdn        (rdn_v[1]),
    .clr_err    (clr_v[1]),
    .dout       (dout_v[1]),
    .data_ready (ready_v[1]),
    .frame_err  (ferr_v[1]),
    .parity_err (perr_v[1]),
    .overrun    (ovr_v[1])
  );

  uart_rx_param #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_8n2 (
    .clk_sample (clk),
    .rst        (rst),
    .rxd        (rxd_v[2]),
    .rdn        (rdn_v[2]),
    .clr_err    (clr_v[2]),
    .dout       (dout_v[2]),
    .data_ready (ready_v[2]),
    .frame_err  (ferr_v[2]),
    .parity_err (perr_v[2]),
    .overrun    (ovr_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then step just past the edge before driving.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One frame, 16 clocks per bit: start, 8 data bits LSB first, optional
  // parity bit, first stop bit, optional second stop bit; line left idle high.
  task automatic send_frame(input int d, input logic [7:0] data, input logic has_par,
                            input logic par, input logic stop1, input int nstop,
                            input logic stop2);
    rxd_v[d] = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd_v[d] = data[i];
      tick(16);
    end
    if (has_par) begin
      rxd_v[d] = par;
      tick(16);
    end
    rxd_v[d] = stop1;
    tick(16);
    if (nstop == 2) begin
      rxd_v[d] = stop2;
      tick(16);
    end
    rxd_v[d] = 1'b1;
  endtask

  task automatic pop_word(input int d);
    rdn_v[d] = 1'b0;
    tick(1);
    rdn_v[d] = 1'b1;
  endtask

  task automatic clear_flags(input int d);
    clr_v[d] = 1'b1;
    tick(1);
    clr_v[d] = 1'b0;
  endtask

  task automatic apply_stimulus(input int idx);
    send_frame(0, vecs[idx].data, 1'b0, 1'b0, vecs[idx].stop_val, 1, 1'b1);
    tick(4);
  endtask

  task automatic check_flags(input int d, input string tag, input logic ef,
                             input logic ep, input logic eo);
    check_output({tag, "_ferr"}, 32'(ferr_v[d]), 32'(ef));
    check_output({tag, "_perr"}, 32'(perr_v[d]), 32'(ep));
    check_output({tag, "_ovr"},  32'(ovr_v[d]),  32'(eo));
  endtask

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    logic ready_seen;

    // Row = {data, stop bit level, expected ready, expected dout, expected frame_err}.
    // The low-stop row is discarded, so dout keeps the previously popped 0xFF.
    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};

    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rxd_v[i] = 1'b1;
      rdn_v[i] = 1'b1;
      clr_v[i] = 1'b0;
    end
    tick(5);
    rst = 1'b1;
    tick(5);

    // Reset state.
    @(negedge clk);
    check_output("rst_dout", 32'(dout_v[0]), 32'h0);
    check_output("rst_ready", 32'(ready_v[0]), 32'h0);
    check_flags(0, "rst", 1'b0, 1'b0, 1'b0);
    check_output("rst_ready_8e1", 32'(ready_v[1]), 32'h0);
    check_output("rst_ready_8n2", 32'(ready_v[2]), 32'h0);

    // 8N1 0xA5 latency: nominal 2 + 9.5*16 + 2 = 156 clocks from the falling
    // edge; the synchroniser / edge-detect alignment allows a couple of clocks.
    tick(1);
    lat = 0;
    ready_seen = 1'b0;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1, 1'b1);
      begin
        while (!ready_seen && lat < 400) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          ready_seen = ready_v[0];
        end
      end
    join
    check_output("lat_ready_seen", 32'(ready_seen), 32'h1);
    total++;
    if (lat < 154 || lat > 158) begin
      bad++;
      $display("[TB] FAIL latency: got %0d cycles expected 154..158", lat);
    end
    tick(4);
    @(negedge clk);
    check_output("a5_dout", 32'(dout_v[0]), 32'hA5);
    check_flags(0, "a5", 1'b0, 1'b0, 1'b0);
    tick(1);
    pop_word(0);
    @(negedge clk);
    check_output("a5_ready_after_pop", 32'(ready_v[0]), 32'h0);
    tick(1);

    // Table-driven 8N1 frames; each row is popped and flags cleared afterwards.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(i);
      @(negedge clk);
      check_output($sformatf("row%0d_ready", i), 32'(ready_v[0]), 32'(vecs[i].exp_ready));
      check_output($sformatf("row%0d_dout", i), 32'(dout_v[0]), 32'(vecs[i].exp_dout));
      check_flags(0, $sformatf("row%0d", i), vecs[i].exp_ferr, 1'b0, 1'b0);
      tick(1);
      pop_word(0);
      clear_flags(0);
      @(negedge clk);
      check_output($sformatf("row%0d_ready_post", i), 32'(ready_v[0]), 32'h0);
      check_output($sformatf("row%0d_dout_hold", i), 32'(dout_v[0]), 32'(vecs[i].exp_dout));
      check_output($sformatf("row%0d_ferr_clr", i), 32'(ferr_v[0]), 32'h0);
      tick(1);
    end

    // False start: 4-clock low glitch, then a real frame must still decode.
    rxd_v[0] = 1'b0;
    tick(4);
    rxd_v[0] = 1'b1;
    tick(40);
    @(negedge clk);
    check_output("fs_ready", 32'(ready_v[0]), 32'h0);
    check_flags(0, "fs", 1'b0, 1'b0, 1'b0);
    tick(1);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    tick(4);
    @(negedge clk);
    check_output("fs_next_dout", 32'(dout_v[0]), 32'hC3);
    check_output("fs_next_ready", 32'(ready_v[0]), 32'h1);
    tick(1);
    pop_word(0);

    // Overrun: five back-to-back frames into a 4-deep FIFO with no reads.
    for (int i = 0; i < 5; i++) begin
      send_frame(0, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1, 1, 1'b1);
    end
    tick(4);
    @(negedge clk);
    check_output("ovr_flag", 32'(ovr_v[0]), 32'h1);
    check_output("ovr_ready", 32'(ready_v[0]), 32'h1);
    check_output("ovr_ferr", 32'(ferr_v[0]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("ovr_pop%0d", i), 32'(dout_v[0]), 32'(8'h10 + i));
      tick(1);
      pop_word(0);
      @(negedge clk);
    end
    check_output("ovr_ready_empty", 32'(ready_v[0]), 32'h0);
    check_output("ovr_dout_hold", 32'(dout_v[0]), 32'h13);
    tick(1);
    clear_flags(0);
    @(negedge clk);
    check_output("ovr_cleared", 32'(ovr_v[0]), 32'h0);
    tick(1);

    // 8E1: 0x03 has two ones, so parity 1 is wrong under even parity.
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1, 1'b1);
    tick(4);
    @(negedge clk);
    check_output("e1_bad_perr", 32'(perr_v[1]), 32'h1);
    check_output("e1_bad_ready", 32'(ready_v[1]), 32'h0);
    check_output("e1_bad_ferr", 32'(ferr_v[1]), 32'h0);
    tick(1);
    clear_flags(1);
    @(negedge clk);
    check_output("e1_perr_clr", 32'(perr_v[1]), 32'h0);
    tick(1);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1, 1'b1);
    tick(4);
    @(negedge clk);
    check_output("e1_good_ready", 32'(ready_v[1]), 32'h1);
    check_output("e1_good_dout", 32'(dout_v[1]), 32'h03);
    check_output("e1_good_perr", 32'(perr_v[1]), 32'h0);
    tick(1);
    pop_word(1);

    // 8N2: low second stop bit is a framing error; the next frame is good.
    send_frame(2, 8'h55, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    tick(4);
    @(negedge clk);
    check_output("n2_bad_ferr", 32'(ferr_v[2]), 32'h1);
    check_output("n2_bad_ready", 32'(ready_v[2]), 32'h0);
    tick(1);
    send_frame(2, 8'h66, 1'b0, 1'b0, 1'b1, 2, 1'b1);
    tick(4);
    @(negedge clk);
    check_output("n2_good_ready", 32'(ready_v[2]), 32'h1);
    check_output("n2_good_dout", 32'(dout_v[2]), 32'h66);
    check_output("n2_ferr_sticky", 32'(ferr_v[2]), 32'h1);
    tick(1);
    clear_flags(2);
    @(negedge clk);
    check_output("n2_ferr_clr", 32'(ferr_v[2]), 32'h0);
    tick(1);

    // Reset in the middle of 0x7E's data bits, held past the end of the frame.
    fork
      send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1, 1, 1'b1);
      begin
        tick(60);
        rst = 1'b0;
        tick(120);
        rst = 1'b1;
      end
    join
    tick(5);
    @(negedge clk);
    check_output("mid_rst_ready", 32'(ready_v[0]), 32'h0);
    check_output("mid_rst_dout", 32'(dout_v[0]), 32'h0);
    check_output("mid_rst_n2_ready", 32'(ready_v[2]), 32'h0);
    check_flags(0, "mid_rst", 1'b0, 1'b0, 1'b0);
    tick(1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    tick(4);
    @(negedge clk);
    check_output("post_rst_ready", 32'(ready_v[0]), 32'h1);
    check_output("post_rst_dout", 32'(dout_v[0]), 32'h81);
    check_flags(0, "post_rst", 1'b0, 1'b0, 1'b0);
    tick(1);
    pop_word(0);
    @(negedge clk);
    check_output("post_rst_single", 32'(ready_v[0]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, meaning clk_sample cycles per bit; even, legal range 8..32.
REQ-003 Parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, meaning receive words held; power of two, legal range 2..16.
REQ-006 Port clk_sample, input, 1, meaning sample clock at OVERSAMPLE x baud; one clock; all state on its rising edge.
REQ-007 Port rst, input, 1, meaning reset; asynchronous, active-low.
REQ-008 Port rxd, input, 1, meaning serial data; asynchronous to clk_sample; idle high.
REQ-009 Port rdn, input, 1, meaning active-low read strobe; pops one word per low cycle.
REQ-010 Port clr_err, input, 1, meaning active-high, one cycle; clears sticky error flags.
REQ-011 Port dout, output, DATA_BITS, meaning FIFO head word; always driven, no tristate.
REQ-012 Port data_ready, output, 1, meaning FIFO not empty.
REQ-013 Port frame_err, output, 1, meaning sticky: a stop bit was sampled low.
REQ-014 Port parity_err, output, 1, meaning sticky: a parity mismatch occurred.
REQ-015 Port overrun, output, 1, meaning sticky: a good frame was dropped because the FIFO was full.

Function
REQ-016 rxd SHALL pass through a 2-flop synchroniser; all logic uses the synchronised value only.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, with one-hot encoding.
REQ-018 IDLE SHALL move to START on a synchronised high-to-low transition and clear the bit-phase counter.
REQ-019 Each bit SHALL be a 3-sample majority vote at phase counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; the decision is taken at OVERSAMPLE/2+1.
REQ-020 In START, a majority of 1 SHALL be a false start: return to IDLE, no flags, no push.
REQ-021 In DATA, bits SHALL shift in LSB first; the bit counter is $clog2(DATA_BITS+1) wide and stops at DATA_BITS.
REQ-022 PARITY SHALL be skipped when PARITY_MODE=0; otherwise mismatch is XOR of data bits and parity bit against 0 (even) or 1 (odd).
REQ-023 STOP SHALL sample STOP_BITS bits; any low stop bit sets frame_err.
REQ-024 The FSM SHALL move to IDLE at the decision point of the last stop bit, not at the bit end, so back-to-back frames are accepted.
REQ-025 A frame SHALL be pushed only if it has no framing error and no parity error; errored frames are discarded and set their flag.
REQ-026 The push SHALL occur in the cycle after the last stop-bit decision; data_ready SHALL rise the following cycle when the FIFO was empty.
REQ-027 The FIFO SHALL show its head word on dout combinationally, and dout SHALL hold its last value when the FIFO is empty.
REQ-028 rdn low with the FIFO not empty SHALL pop one word per cycle; rdn low with the FIFO empty SHALL be ignored.
REQ-029 Push and pop in the same cycle SHALL both happen, including when the FIFO is full; overrun is not set in that case.
REQ-030 A push with the FIFO full and no pop SHALL drop the word and set overrun; FIFO contents stay unchanged.
REQ-031 Pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide with natural wrap-around; full and empty are decided by the MSB comparison.
REQ-032 clr_err SHALL clear all three flags; when a set event and clr_err occur in the same cycle, the set wins.

Reset
REQ-033 rst low SHALL asynchronously force: FSM to IDLE, counters to 0, synchroniser flops to 1, FIFO empty, dout=0, data_ready=0, all flags=0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; after release, reception restarts only on a fresh falling edge.

Structure
REQ-035 Shared package uart_pkg SHALL hold the PARITY_NONE/EVEN/ODD constants and the FSM state encodings, for reuse by the future transmitter.
REQ-036 The FIFO SHALL be a separate sub-module uart_rx_fifo, parametrised by width and depth; the FSM stays in uart_rx_param.

Verification
REQ-037 8N1, OVERSAMPLE=16, send 0xA5 -> data_ready rises 2+9.5*16+2 cycles after the rxd falling edge; dout=0xA5; no flags.
REQ-038 8E1, send 0x03 with parity bit 1 -> parity_err=1, no push; then clr_err -> flag 0; then 0x03 with parity 0 -> dout=0x03.
REQ-039 rxd low pulse of 4 cycles -> false start, FSM back in IDLE, data_ready=0, no flags.
REQ-040 8N1, FIFO_DEPTH=4, five frames 0x10..0x14 with no reads -> overrun=1; four pops return 0x10..0x13 in order, then data_ready=0.
REQ-041 8N2, second stop bit driven low on 0x55 -> frame_err=1, no push; a following 0x66 frame is received correctly.
REQ-042 rst asserted mid-DATA of 0x7E, released, then 0x81 sent -> only 0x81 is received, flags 0.
